// File: rtl/riscv_v_scoreboard_if.sv
// Decode-stage signals shared between the vector ID stage and its register scoreboard.
// Handshake: id_valid offers the ID instruction; it is taken (issue_fire) only when
// !clear_pipe & !riscv_stall & !riscv_v_stall, and must be held unchanged until then.
interface riscv_v_scoreboard_if #(
  parameter int NUM_VREGS = 32,
  parameter int NUM_SRC   = 3,
  parameter int MAX_LAT   = 4,
  parameter int ADDR_W    = $clog2(NUM_VREGS),
  parameter int LAT_W     = $clog2(MAX_LAT+1)
);
  logic                      riscv_stall;
  logic                      clear_pipe;
  logic                      id_valid;
  logic [ADDR_W-1:0]         id_vd;
  logic                      id_vd_we;
  logic [LAT_W-1:0]          id_lat;
  logic [NUM_SRC*ADDR_W-1:0] id_src_addr;
  logic [NUM_SRC-1:0]        id_src_rd;
  logic                      riscv_v_stall;
  logic                      issue_fire;
  logic [NUM_SRC-1:0]        src_fwd;
  logic                      wb_due;
  logic [NUM_VREGS-1:0]      busy;
  logic                      lat_err;

  modport master (
    output riscv_stall, clear_pipe, id_valid, id_vd, id_vd_we, id_lat, id_src_addr, id_src_rd,
    input  riscv_v_stall, issue_fire, src_fwd, wb_due, busy, lat_err
  );

  modport slave (
    input  riscv_stall, clear_pipe, id_valid, id_vd, id_vd_we, id_lat, id_src_addr, id_src_rd,
    output riscv_v_stall, issue_fire, src_fwd, wb_due, busy, lat_err
  );
endinterface

// File: rtl/riscv_v_scoreboard.sv
// Vector register scoreboard: tracks in-flight writes per register and per writeback slot,
// stalls ID on RAW/WAW/writeback-port conflicts and selects forwarding from the writeback bus.
module riscv_v_scoreboard #(
  parameter int NUM_VREGS = 32,
  parameter int NUM_SRC   = 3,
  parameter int MAX_LAT   = 4,
  parameter int ADDR_W    = $clog2(NUM_VREGS),
  parameter int LAT_W     = $clog2(MAX_LAT+1)
) (
  input logic                 clk,
  input logic                 rst,
  riscv_v_scoreboard_if.slave sb
);

  logic [LAT_W-1:0]   cnt_q [NUM_VREGS];
  logic [LAT_W-1:0]   cnt_d [NUM_VREGS];
  logic [MAX_LAT-1:0] slot_q, slot_d;
  logic               lat_err_q, lat_err_d;

  logic               lat_ok;
  logic [LAT_W-1:0]   eff_lat;
  logic [MAX_LAT:0]   slot_ext;
  logic [ADDR_W-1:0]  src_a;
  logic               raw_haz, waw_haz, str_haz;
  logic               v_stall, fire, id_live;
  logic [NUM_SRC-1:0] fwd;
  logic [NUM_VREGS-1:0] busy_vec;

  assign lat_ok   = (sb.id_lat != '0) && (sb.id_lat <= LAT_W'(MAX_LAT));
  assign eff_lat  = lat_ok ? sb.id_lat : LAT_W'(MAX_LAT);
  // Top bit is a permanent zero so slot_ext[MAX_LAT] means "no conflict possible".
  assign slot_ext = {1'b0, slot_q};
  assign id_live  = sb.id_valid && !sb.clear_pipe;

  always_comb begin
    raw_haz = 1'b0;
    fwd     = '0;
    src_a   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_a = sb.id_src_addr[i*ADDR_W +: ADDR_W];
      if (sb.id_src_rd[i] && (cnt_q[src_a] >= LAT_W'(2))) raw_haz = 1'b1;
      fwd[i] = sb.id_valid && sb.id_src_rd[i] && (cnt_q[src_a] == LAT_W'(1));
    end
  end

  assign waw_haz = sb.id_vd_we && (cnt_q[sb.id_vd] > eff_lat);
  assign str_haz = sb.id_vd_we && slot_ext[eff_lat];
  assign v_stall = id_live && (raw_haz || waw_haz || str_haz);
  assign fire    = id_live && !sb.riscv_stall && !v_stall;

  always_comb begin
    for (int r = 0; r < NUM_VREGS; r++) busy_vec[r] = (cnt_q[r] != '0);
  end

  always_comb begin
    slot_d    = slot_q;
    lat_err_d = lat_err_q;
    for (int r = 0; r < NUM_VREGS; r++) cnt_d[r] = cnt_q[r];
    if (!sb.riscv_stall) begin
      for (int r = 0; r < NUM_VREGS; r++) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
      slot_d = {1'b0, slot_q[MAX_LAT-1:1]};
      if (fire && !lat_ok) lat_err_d = 1'b1;
      // A new write overrides the decrement/shift for its register and slot.
      if (fire && sb.id_vd_we) begin
        cnt_d[sb.id_vd] = eff_lat;
        for (int k = 0; k < MAX_LAT; k++) begin
          if (eff_lat == LAT_W'(k+1)) slot_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_VREGS; r++) cnt_q[r] <= '0;
      slot_q    <= '0;
      lat_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_VREGS; r++) cnt_q[r] <= cnt_d[r];
      slot_q    <= slot_d;
      lat_err_q <= lat_err_d;
    end
  end

  assign sb.riscv_v_stall = v_stall;
  assign sb.issue_fire    = fire;
  assign sb.src_fwd       = fwd;
  assign sb.wb_due        = slot_q[0];
  assign sb.busy          = busy_vec;
  assign sb.lat_err       = lat_err_q;

endmodule
